// File: rtl/cordic_engine.sv
// Fully pipelined CORDIC engine: rotation (sin/cos, vector rotate) or vectoring (magnitude, atan2)
// selected per sample. Input capture rank, quadrant pre-rotation rank, then ITER micro-rotation ranks.

module cordic_engine #(
    parameter int WIDTH = 16,
    parameter int ITER  = WIDTH - 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic        [31:0]      z_in,
    output logic                    out_valid,
    output logic                    out_mode,
    output logic signed [WIDTH+1:0] x_out,
    output logic signed [WIDTH+1:0] y_out,
    output logic        [31:0]      z_out
);

    localparam int DW = WIDTH + 2;

    generate
        if (WIDTH < 8 || WIDTH > 30 || ITER < 4 || ITER > 31) begin : g_bad_params
            $error("cordic_engine: WIDTH must be 8..30 and ITER must be 4..31");
        end
    endgenerate

    // round(atan(2^-i) * 2^32 / 360deg), i.e. binary angle with 2^32 = full circle
    function automatic logic [31:0] atan_lut(input int i);
        case (i)
            0:       atan_lut = 32'h2000_0000;
            1:       atan_lut = 32'h12E4_051E;
            2:       atan_lut = 32'h09FB_385B;
            3:       atan_lut = 32'h0511_11D4;
            4:       atan_lut = 32'h028B_0D43;
            5:       atan_lut = 32'h0145_D7E1;
            6:       atan_lut = 32'h00A2_F61E;
            7:       atan_lut = 32'h0051_7C55;
            8:       atan_lut = 32'h0028_BE53;
            9:       atan_lut = 32'h0014_5F2F;
            10:      atan_lut = 32'h000A_2F98;
            11:      atan_lut = 32'h0005_17CC;
            12:      atan_lut = 32'h0002_8BE6;
            13:      atan_lut = 32'h0001_45F3;
            14:      atan_lut = 32'h0000_A2FA;
            15:      atan_lut = 32'h0000_517D;
            16:      atan_lut = 32'h0000_28BE;
            17:      atan_lut = 32'h0000_145F;
            18:      atan_lut = 32'h0000_0A30;
            19:      atan_lut = 32'h0000_0518;
            20:      atan_lut = 32'h0000_028C;
            21:      atan_lut = 32'h0000_0146;
            22:      atan_lut = 32'h0000_00A3;
            23:      atan_lut = 32'h0000_0051;
            24:      atan_lut = 32'h0000_0029;
            25:      atan_lut = 32'h0000_0014;
            26:      atan_lut = 32'h0000_000A;
            27:      atan_lut = 32'h0000_0005;
            28:      atan_lut = 32'h0000_0003;
            29:      atan_lut = 32'h0000_0001;
            30:      atan_lut = 32'h0000_0001;
            default: atan_lut = 32'h0000_0000;
        endcase
    endfunction

    logic signed [DW-1:0] xi_q, yi_q;
    logic        [31:0]   zi_q;
    logic                 vi_q, mi_q;

    logic signed [DW-1:0] x_pre, y_pre;
    logic        [31:0]   z_pre;

    logic signed [DW-1:0] x0_q, y0_q;
    logic        [31:0]   z0_q;
    logic        [ITER:0] v_q, m_q;

    logic signed [DW-1:0] x_w [0:ITER];
    logic signed [DW-1:0] y_w [0:ITER];
    logic        [31:0]   z_w [0:ITER];

    // Fold the vector into the right half-plane so the micro-rotations (which cover
    // roughly +/-99.9 deg) can converge; the folded angle is preloaded into z.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches are inferred.
        x_pre = xi_q;
        y_pre = yi_q;
        z_pre = zi_q;
        if (!mi_q) begin
            case (zi_q[31:30])
                2'b01: begin
                    x_pre = -yi_q;
                    y_pre = xi_q;
                    z_pre = {2'b00, zi_q[29:0]};
                end
                2'b10: begin
                    x_pre = yi_q;
                    y_pre = -xi_q;
                    z_pre = {2'b11, zi_q[29:0]};
                end
                default: ;
            endcase
        end else begin
            z_pre = 32'h0000_0000;
            if (xi_q[DW-1]) begin
                if (!yi_q[DW-1]) begin
                    x_pre = yi_q;
                    y_pre = -xi_q;
                    z_pre = 32'h4000_0000;
                end else begin
                    x_pre = -yi_q;
                    y_pre = xi_q;
                    z_pre = 32'hC000_0000;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: every data rank is reset, not just the valid bits, so reset also forces
        // the data outputs to zero and nothing stale survives into the next run.
        if (!reset_n) begin
            xi_q <= '0;
            yi_q <= '0;
            zi_q <= '0;
            vi_q <= 1'b0;
            mi_q <= 1'b0;
            x0_q <= '0;
            y0_q <= '0;
            z0_q <= '0;
            v_q  <= '0;
            m_q  <= '0;
        end else begin
            // NOTE: non-blocking so each rank takes the previous rank's pre-edge value.
            xi_q <= {{2{x_in[WIDTH-1]}}, x_in};
            yi_q <= {{2{y_in[WIDTH-1]}}, y_in};
            zi_q <= z_in;
            vi_q <= in_valid;
            mi_q <= mode;
            x0_q <= x_pre;
            y0_q <= y_pre;
            z0_q <= z_pre;
            v_q  <= {v_q[ITER-1:0], vi_q};
            m_q  <= {m_q[ITER-1:0], mi_q};
        end
    end

    assign x_w[0] = x0_q;
    assign y_w[0] = y0_q;
    assign z_w[0] = z0_q;

    for (genvar s = 0; s < ITER; s++) begin : g_stage
        logic                 dir;
        logic signed [DW-1:0] x_sh, y_sh;
        logic signed [DW-1:0] x_r, y_r;
        logic        [31:0]   z_r;

        // Rotation drives z to zero; vectoring drives y to zero.
        assign dir  = m_q[s] ? ~y_w[s][DW-1] : z_w[s][31];
        assign x_sh = x_w[s] >>> s;
        assign y_sh = y_w[s] >>> s;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                x_r <= '0;
                y_r <= '0;
                z_r <= '0;
            end else if (dir) begin
                x_r <= x_w[s] + y_sh;
                y_r <= y_w[s] - x_sh;
                z_r <= z_w[s] + atan_lut(s);
            end else begin
                x_r <= x_w[s] - y_sh;
                y_r <= y_w[s] + x_sh;
                z_r <= z_w[s] - atan_lut(s);
            end
        end

        assign x_w[s+1] = x_r;
        assign y_w[s+1] = y_r;
        assign z_w[s+1] = z_r;
    end

    assign out_valid = v_q[ITER];
    assign out_mode  = m_q[ITER];
    assign x_out     = x_w[ITER];
    assign y_out     = y_w[ITER];
    assign z_out     = z_w[ITER];

endmodule

// File: tb/tb_cordic_engine.sv
// Scoreboard bench for cordic_engine: a behavioural CORDIC model predicts each result and its
// arrival edge; directed vectors are also held to true-trig values within tolerance.

module tb_cordic_engine;

    localparam int    WIDTH  = 16;
    localparam int    ITER   = 15;
    localparam int    LAT    = ITER + 1;
    localparam int    XY_TOL = 4;
    localparam int    Z_TOL  = 32'h0010_0000;
    localparam real   PI     = 3.14159265358979323846;

    logic                    clock = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    mode = 1'b0;
    logic signed [WIDTH-1:0] x_in = '0;
    logic signed [WIDTH-1:0] y_in = '0;
    logic        [31:0]      z_in = '0;
    logic                    out_valid;
    logic                    out_mode;
    logic signed [WIDTH+1:0] x_out;
    logic signed [WIDTH+1:0] y_out;
    logic        [31:0]      z_out;

    cordic_engine #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_mode  (out_mode),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out)
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt++;

    typedef struct {
        int          due;
        bit          mode;
        int          x;
        int          y;
        logic [31:0] z;
        bit          has_ref;
        int          rx;
        int          ry;
        logic [31:0] rz;
    } rec_t;

    rec_t   sb[$];
    longint atab [0:30];
    int     n_vec = 0;
    int     n_err = 0;

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        longint diff;
        diff = got - exp;
        n_vec++;
        if (diff > tol || diff < -tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at edge %0d", tag, got, exp, tol, edge_cnt);
        end
    endtask

    function automatic void cordic_ref(input bit m, input int xi, input int yi, input logic [31:0] zi,
                                       output int xo, output int yo, output logic [31:0] zo);
        int          x, y, xt;
        logic [31:0] z;
        bit          d;
        x = xi;
        y = yi;
        z = m ? 32'h0 : zi;
        if (!m) begin
            if (zi[31:30] == 2'b01) begin
                x = -yi; y = xi; z = {2'b00, zi[29:0]};
            end else if (zi[31:30] == 2'b10) begin
                x = yi; y = -xi; z = {2'b11, zi[29:0]};
            end
        end else if (xi < 0) begin
            if (yi >= 0) begin
                x = yi; y = -xi; z = 32'h4000_0000;
            end else begin
                x = -yi; y = xi; z = 32'hC000_0000;
            end
        end
        for (int i = 0; i < ITER; i++) begin
            d  = m ? (y >= 0) : z[31];
            xt = x;
            if (d) begin
                x = x + (y >>> i);
                y = y - (xt >>> i);
                z = z + 32'(atab[i]);
            end else begin
                x = x - (y >>> i);
                y = y + (xt >>> i);
                z = z - 32'(atab[i]);
            end
        end
        xo = x;
        yo = y;
        zo = z;
    endfunction

    task automatic apply(input bit v, input bit m, input int x, input int y, input logic [31:0] z,
                         input bit has_ref, input int rx, input int ry, input logic [31:0] rz);
        rec_t r;
        in_valid = v;
        mode     = m;
        x_in     = x[15:0];
        y_in     = y[15:0];
        z_in     = z;
        if (v && reset_n) begin
            cordic_ref(m, x, y, z, r.x, r.y, r.z);
            r.due     = edge_cnt + 1 + LAT;
            r.mode    = m;
            r.has_ref = has_ref;
            r.rx      = rx;
            r.ry      = ry;
            r.rz      = rz;
            sb.push_back(r);
        end
    endtask

    task automatic send(input bit m, input int x, input int y, input logic [31:0] z);
        @(negedge clock);
        apply(1'b1, m, x, y, z, 1'b0, 0, 0, 32'h0);
    endtask

    task automatic send_ref(input bit m, input int x, input int y, input logic [31:0] z,
                            input int rx, input int ry, input logic [31:0] rz);
        @(negedge clock);
        apply(1'b1, m, x, y, z, 1'b1, rx, ry, rz);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            apply(1'b0, 1'($urandom_range(0, 1)), rnd16(), rnd16(), $urandom(), 1'b0, 0, 0, 32'h0);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic check_zero_outputs(input string phase);
        check({phase, "_out_valid"}, out_valid, 0, 0);
        check({phase, "_out_mode"},  out_mode,  0, 0);
        check({phase, "_x_out"},     x_out,     0, 0);
        check({phase, "_y_out"},     y_out,     0, 0);
        check({phase, "_z_out"},     z_out,     0, 0);
    endtask

    always @(negedge clock) begin : monitor
        rec_t               r;
        logic signed [31:0] zd;
        if (reset_n) begin
            if (sb.size() > 0 && sb[0].due == edge_cnt) begin
                r = sb.pop_front();
                check("out_valid", out_valid, 1, 0);
                check("out_mode",  out_mode,  r.mode, 0);
                check("x_out",     x_out,     r.x, 0);
                check("y_out",     y_out,     r.y, 0);
                check("z_out",     z_out,     r.z, 0);
                if (r.has_ref) begin
                    zd = z_out - r.rz;
                    check("x_trig", x_out, r.rx, XY_TOL);
                    check("y_trig", y_out, r.ry, XY_TOL);
                    check("z_trig", longint'(r.rz) + zd, r.rz, Z_TOL);
                end
            end else if (out_valid) begin
                check("unexpected_out_valid", out_valid, 0, 0);
            end
        end
    end

    initial begin
        for (int i = 0; i <= 30; i++)
            atab[i] = longint'($rtoi($atan(1.0 / (2.0 ** i)) * 2147483648.0 / PI + 0.5));

        // Reset state
        repeat (3) @(negedge clock);
        #1 check_zero_outputs("reset");

        @(negedge clock);
        reset_n = 1'b1;

        // Directed vectors against true trigonometry
        send_ref(1'b0, 19429, 0, 32'h1555_5555, 27708, 15997, 32'h0);
        send_ref(1'b0, 19429, 0, 32'h5555_5555, -15997, 27708, 32'h0);
        send_ref(1'b0, 19429, 0, 32'hAAAA_AAAB, -15997, -27708, 32'h0);
        send_ref(1'b1, -10000, 10000, 32'h1234_5678, 23289, 0, 32'h6000_0000);
        send_ref(1'b1, 10000, -10000, 32'h0, 23289, 0, 32'hE000_0000);
        send_ref(1'b1, -32768, -32768, 32'h0, 76311, 0, 32'hA000_0000);
        send_ref(1'b0, 32767, 32767, 32'h2000_0000, 0, 76311, 32'h0);
        idle(LAT + 3);

        // Mixed-mode stream with a two-cycle bubble
        for (int k = 0; k < 40; k++) begin
            if (k == 10 || k == 11) idle(1);
            else send(1'(k % 2), rnd16(), rnd16(), $urandom());
        end
        idle(LAT + 3);

        // Reset mid-flight: everything in the pipe is discarded
        for (int k = 0; k < 5; k++) send(1'(k % 2), rnd16(), rnd16(), $urandom());
        @(negedge clock);
        apply(1'b1, 1'b0, rnd16(), rnd16(), $urandom(), 1'b0, 0, 0, 32'h0);
        #2 reset_n = 1'b0;
        sb.delete();
        #1 check_zero_outputs("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        apply(1'b1, 1'b0, 19429, 0, 32'h1555_5555, 1'b1, 27708, 15997, 32'h0);
        send(1'b1, rnd16(), rnd16(), $urandom());
        send(1'b0, rnd16(), rnd16(), $urandom());
        idle(LAT + 4);

        check("scoreboard_drained", sb.size(), 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
